// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: branch resolve, wait-stated data RAM, MEM/WB register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InWB,
  input  logic              InZero,
  input  logic              InBranch,
  input  logic              InMemWrite,
  input  logic              InMemRead,
  input  logic [DATA_W-1:0] InAddResult,
  input  logic [DATA_W-1:0] InALUResult,
  input  logic [DATA_W-1:0] InReadData2,
  input  logic [4:0]        InMux,
  output logic              PCSrc,
  output logic [DATA_W-1:0] BranchTarget,
  output logic              Stall,
  output logic              OutWB,
  output logic [DATA_W-1:0] OutReadData,
  output logic [DATA_W-1:0] OutALUResult,
  output logic [4:0]        OutMux,
  output logic              MisalignErr
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic              r_mis_err;
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  logic              w_req;
  logic              w_complete;
  logic              w_load;
  logic              w_misalign;
  logic [ADDR_W-1:0] w_word;
  logic              w_unused;

  assign PCSrc        = InBranch & InZero;
  assign BranchTarget = InAddResult;
  assign w_req        = InMemRead | InMemWrite;
  // Upper address bits are dropped so out-of-range addresses wrap.
  assign w_word       = InALUResult[ADDR_W+1:2];
  assign w_unused     = ^{InALUResult[DATA_W-1:ADDR_W+2], InALUResult[1:0]};

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_req & (InALUResult[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    Stall      = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (LATENCY == 0) begin
            w_complete = 1'b1;
          end else begin
            Stall      = 1'b1;
            w_next     = BUSY;
            w_cnt_next = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          Stall      = 1'b1;
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_load = ((r_state == IDLE) && !w_req) || w_complete;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_mis_err    <= 1'b0;
      OutWB        <= 1'b0;
      OutReadData  <= '0;
      OutALUResult <= '0;
      OutMux       <= 5'd0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_mis_err <= w_complete & w_misalign;
      if (w_load) begin
        OutWB        <= InWB & ~(w_complete & w_misalign);
        OutALUResult <= InALUResult;
        OutMux       <= InMux;
        // A simultaneous read+write is a store, so only pure loads return data.
        if (w_complete && InMemRead && !InMemWrite && !w_misalign)
          OutReadData <= r_mem[w_word];
        else
          OutReadData <= '0;
      end else begin
        OutWB <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_complete && InMemWrite && !w_misalign)
      r_mem[w_word] <= InReadData2;
  end

  assign MisalignErr = r_mis_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage (LATENCY 2 and 0).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_wb, in_zero, in_branch;
  logic        mem_read, mem_write, mem_read0, mem_write0;
  logic [31:0] add_result, alu_result, read_data2;
  logic [4:0]  in_mux;

  logic        pcsrc, stall, out_wb, mis_err;
  logic [31:0] br_target, out_rdata, out_alu;
  logic [4:0]  out_mux;

  logic        pcsrc0, stall0, out_wb0, mis_err0;
  logic [31:0] br_target0, out_rdata0, out_alu0;
  logic [4:0]  out_mux0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .ADDR_W(8), .LATENCY(2)) u_dut (
    .Clk(clk), .Reset(rst), .InWB(in_wb), .InZero(in_zero), .InBranch(in_branch),
    .InMemWrite(mem_write), .InMemRead(mem_read), .InAddResult(add_result),
    .InALUResult(alu_result), .InReadData2(read_data2), .InMux(in_mux),
    .PCSrc(pcsrc), .BranchTarget(br_target), .Stall(stall), .OutWB(out_wb),
    .OutReadData(out_rdata), .OutALUResult(out_alu), .OutMux(out_mux), .MisalignErr(mis_err)
  );

  mem_access_stage #(.DATA_W(32), .ADDR_W(8), .LATENCY(0)) u_dut0 (
    .Clk(clk), .Reset(rst), .InWB(in_wb), .InZero(in_zero), .InBranch(in_branch),
    .InMemWrite(mem_write0), .InMemRead(mem_read0), .InAddResult(add_result),
    .InALUResult(alu_result), .InReadData2(read_data2), .InMux(in_mux),
    .PCSrc(pcsrc0), .BranchTarget(br_target0), .Stall(stall0), .OutWB(out_wb0),
    .OutReadData(out_rdata0), .OutALUResult(out_alu0), .OutMux(out_mux0), .MisalignErr(mis_err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic wb, input logic [4:0] mux);
    mem_read   = rd;
    mem_write  = wr;
    alu_result = addr;
    read_data2 = data;
    in_wb      = wb;
    in_mux     = mux;
    #1;
  endtask

  task automatic set_nop();
    set_op(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic run_access();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_zero = 1'b0; in_branch = 1'b0; add_result = 32'h0;
    mem_read0 = 1'b0; mem_write0 = 1'b0;
    set_nop();
    repeat (2) tick();
    n_checks++;
    if (out_wb !== 1'b0 || out_rdata !== 32'h0 || out_alu !== 32'h0 || out_mux !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wb=%0b rd=%h alu=%h mux=%0d want all 0", out_wb, out_rdata, out_alu, out_mux);
    end
    n_checks++;
    if (stall !== 1'b0 || mis_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall_err: got stall=%0b err=%0b want 0 0", stall, mis_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    set_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 5'd3);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL store_stall_c0: got %0b want 1", stall); end
    tick();
    n_checks++;
    if (stall !== 1'b1 || out_wb !== 1'b0) begin
      n_fail++; $display("FAIL store_stall_c1: got stall=%0b wb=%0b want 1 0", stall, out_wb);
    end
    tick();
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL store_stall_c2: got %0b want 0", stall); end
    tick();
    n_checks++;
    if (out_rdata !== 32'h0 || out_mux !== 5'd3 || out_alu !== 32'h10) begin
      n_fail++; $display("FAIL store_complete: got rd=%h mux=%0d alu=%h want 0 3 10", out_rdata, out_mux, out_alu);
    end
    set_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 5'd7);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL back_to_back_stall: got %0b want 1", stall); end
    run_access();
    n_checks++;
    if (out_rdata !== 32'hDEADBEEF || out_wb !== 1'b1 || out_mux !== 5'd7) begin
      n_fail++; $display("FAIL load_result: got rd=%h wb=%0b mux=%0d want deadbeef 1 7", out_rdata, out_wb, out_mux);
    end
    set_nop();
    tick();
  endtask

  task automatic test_reset_mid_access();
    set_op(1'b0, 1'b1, 32'h8, 32'h11111111, 1'b0, 5'd1);
    run_access();
    set_op(1'b0, 1'b1, 32'h8, 32'h22222222, 1'b1, 5'd2);
    tick();
    rst = 1'b1;
    set_nop();
    n_checks++;
    if (out_wb !== 1'b0 || out_rdata !== 32'h0 || out_alu !== 32'h0 || out_mux !== 5'd0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got wb=%0b rd=%h alu=%h mux=%0d stall=%0b want all 0", out_wb, out_rdata, out_alu, out_mux, stall);
    end
    tick();
    rst = 1'b0;
    set_op(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 5'd4);
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL midreset_idle: got stall=%0b want 1", stall); end
    run_access();
    n_checks++;
    if (out_rdata !== 32'h11111111) begin
      n_fail++; $display("FAIL midreset_ram: got %h want 11111111", out_rdata);
    end
    set_nop();
    tick();
  endtask

  task automatic test_non_mem();
    set_op(1'b0, 1'b0, 32'h55, 32'h0, 1'b1, 5'd9);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL nonmem_stall: got %0b want 0", stall); end
    tick();
    n_checks++;
    if (out_wb !== 1'b1 || out_alu !== 32'h55 || out_mux !== 5'd9 || stall !== 1'b0) begin
      n_fail++; $display("FAIL nonmem_load: got wb=%0b alu=%h mux=%0d stall=%0b want 1 55 9 0", out_wb, out_alu, out_mux, stall);
    end
    set_nop();
    tick();
  endtask

  task automatic test_branch();
    in_branch = 1'b1; in_zero = 1'b1; add_result = 32'h40;
    #1;
    n_checks++;
    if (pcsrc !== 1'b1 || br_target !== 32'h40) begin
      n_fail++; $display("FAIL branch_taken: got pcsrc=%0b tgt=%h want 1 40", pcsrc, br_target);
    end
    in_zero = 1'b0;
    #1;
    n_checks++;
    if (pcsrc !== 1'b0) begin n_fail++; $display("FAIL branch_not_taken: got %0b want 0", pcsrc); end
    in_branch = 1'b0; add_result = 32'h0;
    tick();
  endtask

  task automatic test_wrap_and_zero_latency();
    set_op(1'b0, 1'b1, 32'h404, 32'h5A5A0001, 1'b0, 5'd0);
    run_access();
    set_op(1'b1, 1'b0, 32'h004, 32'h0, 1'b1, 5'd5);
    run_access();
    n_checks++;
    if (out_rdata !== 32'h5A5A0001) begin
      n_fail++; $display("FAIL wrap_load: got %h want 5a5a0001", out_rdata);
    end
    set_nop();
    tick();
    alu_result = 32'h404; read_data2 = 32'h0BAD0404; mem_write0 = 1'b1;
    #1;
    n_checks++;
    if (stall0 !== 1'b0) begin n_fail++; $display("FAIL lat0_store_stall: got %0b want 0", stall0); end
    tick();
    mem_write0 = 1'b0; mem_read0 = 1'b1; alu_result = 32'h4; in_wb = 1'b1; in_mux = 5'd12;
    #1;
    n_checks++;
    if (stall0 !== 1'b0) begin n_fail++; $display("FAIL lat0_load_stall: got %0b want 0", stall0); end
    tick();
    n_checks++;
    if (out_rdata0 !== 32'h0BAD0404 || out_wb0 !== 1'b1 || out_mux0 !== 5'd12) begin
      n_fail++; $display("FAIL lat0_load: got rd=%h wb=%0b mux=%0d want 0bad0404 1 12", out_rdata0, out_wb0, out_mux0);
    end
    mem_read0 = 1'b0;
    set_nop();
    tick();
  endtask

  task automatic test_misalign();
    set_op(1'b0, 1'b1, 32'h13, 32'hCAFE0013, 1'b1, 5'd6);
    run_access();
`ifdef MISALIGN_TRAP_EN
    n_checks++;
    if (mis_err !== 1'b1 || out_wb !== 1'b0 || out_rdata !== 32'h0) begin
      n_fail++; $display("FAIL misalign_trap: got err=%0b wb=%0b rd=%h want 1 0 0", mis_err, out_wb, out_rdata);
    end
    set_nop();
    tick();
    n_checks++;
    if (mis_err !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %0b want 0", mis_err); end
    set_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 5'd8);
    run_access();
    n_checks++;
    if (out_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL misalign_ram: got %h want deadbeef", out_rdata);
    end
`else
    n_checks++;
    if (mis_err !== 1'b0 || out_wb !== 1'b1) begin
      n_fail++; $display("FAIL misalign_ignored: got err=%0b wb=%0b want 0 1", mis_err, out_wb);
    end
    set_op(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 5'd8);
    run_access();
    n_checks++;
    if (out_rdata !== 32'hCAFE0013 || mis_err !== 1'b0) begin
      n_fail++; $display("FAIL misalign_ram: got rd=%h err=%0b want cafe0013 0", out_rdata, mis_err);
    end
`endif
    set_nop();
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_reset_mid_access();
    test_non_mem();
    test_branch();
    test_wrap_and_zero_latency();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
